u_wb: RTL and testbench

Register-file writeback arbiter with long-latency scoreboard. Merges single-cycle ALU results and handshaked load/store-unit (LSU) results onto the single regfile write port (rd_e/rd_a/rd_i), buffers LSU results in a small FIFO, and tracks registers with outstanding LSU writes so issue logic can stall on RAW hazards. Sits between the execute stage and u_rf, driving the regfile's write inputs.

---
 rtl/u_wb.sv | 130 +++++++++++++
 tb/tb_u_wb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/u_wb.sv
// u_wb: regfile writeback arbiter merging single-cycle ALU results with FIFO-buffered LSU results.
// Define U_WB_SB_EN to build the pending-register scoreboard that drives busy1/busy2.
module u_wb #(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_v,
   input  logic [4:0]  alu_rd_a,
   input  logic [31:0] alu_rd_i,
   output logic        alu_stall,
   input  logic        lsu_v,
   output logic        lsu_rdy,
   input  logic [4:0]  lsu_rd_a,
   input  logic [31:0] lsu_rd_i,
   input  logic        iss_e,
   input  logic [4:0]  iss_a,
   input  logic [4:0]  chk1_a,
   input  logic [4:0]  chk2_a,
   output logic        busy1,
   output logic        busy2,
   output logic        rd_e,
   output logic [4:0]  rd_a,
   output logic [31:0] rd_i
);

   localparam int         AW         = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   logic [4:0]  fifo_a [FIFO_DEPTH];
   logic [31:0] fifo_d [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [2:0]  starve_cnt;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic        sel_alu;
   logic [4:0]  head_a;
   logic [31:0] head_d;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign lsu_rdy   = !full;
   assign push      = lsu_v && !full;
   assign alu_stall = (starve_cnt == STARVE_LIM) && !empty;
   assign sel_alu   = alu_v && !alu_stall;
   assign pop       = !empty && !sel_alu;
   assign head_a    = fifo_a[rd_ptr[AW-1:0]];
   assign head_d    = fifo_d[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_a[wr_ptr[AW-1:0]] <= lsu_rd_a;
         fifo_d[wr_ptr[AW-1:0]] <= lsu_rd_i;
      end
   end

   // Starve counter only grows while ALU keeps beating a waiting FIFO head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         starve_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (pop || empty)
            starve_cnt <= '0;
         else if (sel_alu && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 3'd1;
      end
   end

   // Writes to x0 are dropped so u_rf never forwards a bogus x0 value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_e <= 1'b0;
         rd_a <= '0;
         rd_i <= '0;
      end else if (sel_alu) begin
         rd_e <= (alu_rd_a != 5'd0);
         rd_a <= alu_rd_a;
         rd_i <= alu_rd_i;
      end else if (pop) begin
         rd_e <= (head_a != 5'd0);
         rd_a <= head_a;
         rd_i <= head_d;
      end else begin
         rd_e <= 1'b0;
      end
   end

`ifdef U_WB_SB_EN
   logic [31:0] pending;
   logic [31:0] pending_nxt;

   // Set is applied after clear so a re-issue in the pop cycle keeps the bit.
   always_comb begin
      pending_nxt = pending;
      if (pop && (head_a != 5'd0))
         pending_nxt[head_a] = 1'b0;
      if (iss_e && (iss_a != 5'd0))
         pending_nxt[iss_a] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

   assign busy1 = pending[chk1_a];
   assign busy2 = pending[chk2_a];
`else
   logic unused_sb;
   assign unused_sb = ^{iss_e, iss_a, chk1_a, chk2_a};
   assign busy1     = 1'b0;
   assign busy2     = 1'b0;
`endif

endmodule

// File: tb/tb_u_wb.sv
// tb_u_wb: directed bench for u_wb; expected regfile writes go through a queue checked by a monitor.
module tb_u_wb;

`ifdef U_WB_SB_EN
   localparam logic SB = 1'b1;
`else
   localparam logic SB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_v = 1'b0;
   logic [4:0]  alu_rd_a = '0;
   logic [31:0] alu_rd_i = '0;
   logic        alu_stall;
   logic        lsu_v = 1'b0;
   logic        lsu_rdy;
   logic [4:0]  lsu_rd_a = '0;
   logic [31:0] lsu_rd_i = '0;
   logic        iss_e = 1'b0;
   logic [4:0]  iss_a = '0;
   logic [4:0]  chk1_a = '0;
   logic [4:0]  chk2_a = '0;
   logic        busy1;
   logic        busy2;
   logic        rd_e;
   logic [4:0]  rd_a;
   logic [31:0] rd_i;

   always #5 clk = ~clk;

   u_wb #(.FIFO_DEPTH(2), .STARVE_MAX(3)) dut (
      .clk(clk), .rst(rst),
      .alu_v(alu_v), .alu_rd_a(alu_rd_a), .alu_rd_i(alu_rd_i), .alu_stall(alu_stall),
      .lsu_v(lsu_v), .lsu_rdy(lsu_rdy), .lsu_rd_a(lsu_rd_a), .lsu_rd_i(lsu_rd_i),
      .iss_e(iss_e), .iss_a(iss_a), .chk1_a(chk1_a), .chk2_a(chk2_a),
      .busy1(busy1), .busy2(busy2),
      .rd_e(rd_e), .rd_a(rd_a), .rd_i(rd_i)
   );

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      int          e;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   edge_cnt = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic ie, input logic [4:0] ia);
      @(negedge clk);
      alu_v    = av;
      alu_rd_a = aa;
      alu_rd_i = ad;
      lsu_v    = lv;
      lsu_rd_a = la;
      lsu_rd_i = ld;
      iss_e    = ie;
      iss_a    = ia;
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
   endtask

   // The write is expected to appear right after the upcoming clock edge.
   task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
      exp_t x;
      x.a = a;
      x.d = d;
      x.e = edge_cnt + 1;
      exp_q.push_back(x);
   endtask

   // Monitor: every edge either retires the oldest expected write or must show rd_e low.
   always @(posedge clk) begin
      edge_cnt++;
      #1;
      if (exp_q.size() > 0 && exp_q[0].e <= edge_cnt) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (rd_e !== 1'b1 || rd_a !== mon_e.a || rd_i !== mon_e.d || mon_e.e != edge_cnt) begin
            failures++;
            $display("[TB] FAIL write_edge%0d: got rd_e=%0b rd_a=%0d rd_i=0x%0h expected rd_e=1 rd_a=%0d rd_i=0x%0h",
                     mon_e.e, rd_e, rd_a, rd_i, mon_e.a, mon_e.d);
         end
      end else if (rd_e !== 1'b0) begin
         checks++;
         failures++;
         $display("[TB] FAIL unexpected_write_edge%0d: got rd_e=%0b rd_a=%0d rd_i=0x%0h expected rd_e=0",
                  edge_cnt, rd_e, rd_a, rd_i);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no end of stimulus, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values while rst is held.
      #2;
      checkOutput("rst_rd_e", rd_e, 0);
      checkOutput("rst_rd_a", rd_a, 0);
      checkOutput("rst_rd_i", rd_i, 0);
      checkOutput("rst_lsu_rdy", lsu_rdy, 1);
      checkOutput("rst_alu_stall", alu_stall, 0);
      checkOutput("rst_busy1", busy1, 0);
      checkOutput("rst_busy2", busy2, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single ALU write, then rd_e drops.
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      expectWrite(5'd5, 32'hDEADBEEF);
      idleCycle();
      checkOutput("alu_rd_e", rd_e, 1);
      checkOutput("alu_rd_i", rd_i, 32'hDEADBEEF);
      idleCycle();
      checkOutput("alu_rd_e_drop", rd_e, 0);

      // Long-latency issue to x7, LSU result arrives two cycles later.
      chk1_a = 5'd7;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
      checkOutput("busy_before_iss", busy1, 0);
      idleCycle();
      checkOutput("busy_set", busy1, SB);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
      checkOutput("busy_hold", busy1, SB);
      idleCycle();
      expectWrite(5'd7, 32'h1234);
      checkOutput("busy_queued", busy1, SB);
      idleCycle();
      checkOutput("busy_clear", busy1, 0);
      checkOutput("lsu_rd_a", rd_a, 7);

      // x0 from both sources never raises rd_e; FIFO still drains.
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0);
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h66, 1'b0, 5'd0);
      checkOutput("x0_one_entry_rdy", lsu_rdy, 1);
      idleCycle();
      checkOutput("x0_full", lsu_rdy, 0);
      idleCycle();
      checkOutput("x0_drain_rdy", lsu_rdy, 1);
      idleCycle();
      checkOutput("x0_rd_e", rd_e, 0);

      // ALU wins three times over a full FIFO, then is stalled for one pop.
      applyStimulus(1'b1, 5'd10, 32'hA0000000, 1'b1, 5'd11, 32'hB0000000, 1'b0, 5'd0);
      expectWrite(5'd10, 32'hA0000000);
      applyStimulus(1'b1, 5'd12, 32'hA0000001, 1'b1, 5'd13, 32'hB0000001, 1'b0, 5'd0);
      expectWrite(5'd12, 32'hA0000001);
      applyStimulus(1'b1, 5'd14, 32'hA0000002, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      expectWrite(5'd14, 32'hA0000002);
      checkOutput("starve_full", lsu_rdy, 0);
      checkOutput("starve_no_stall1", alu_stall, 0);
      applyStimulus(1'b1, 5'd15, 32'hA0000003, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      expectWrite(5'd15, 32'hA0000003);
      checkOutput("starve_no_stall2", alu_stall, 0);
      applyStimulus(1'b1, 5'd16, 32'hA0000004, 1'b1, 5'd17, 32'hC0000000, 1'b0, 5'd0);
      expectWrite(5'd11, 32'hB0000000);
      checkOutput("starve_stall", alu_stall, 1);
      checkOutput("starve_still_full", lsu_rdy, 0);
      applyStimulus(1'b1, 5'd16, 32'hA0000004, 1'b1, 5'd17, 32'hC0000000, 1'b0, 5'd0);
      expectWrite(5'd16, 32'hA0000004);
      checkOutput("starve_released", alu_stall, 0);
      checkOutput("starve_slot_free", lsu_rdy, 1);
      idleCycle();
      expectWrite(5'd13, 32'hB0000001);
      idleCycle();
      expectWrite(5'd17, 32'hC0000000);
      idleCycle();

      // Re-issue of x9 in the same cycle its LSU result pops keeps it pending.
      chk1_a = 5'd9;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
      checkOutput("x9_busy", busy1, SB);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
      expectWrite(5'd9, 32'h99);
      idleCycle();
      checkOutput("set_wins", busy1, SB);

      // Reset asserted mid-cycle with a full FIFO and pending bits.
      chk1_a = 5'd3;
      chk2_a = 5'd4;
      applyStimulus(1'b1, 5'd20, 32'h20202020, 1'b1, 5'd21, 32'h21212121, 1'b1, 5'd3);
      expectWrite(5'd20, 32'h20202020);
      applyStimulus(1'b1, 5'd22, 32'h22222222, 1'b1, 5'd23, 32'h23232323, 1'b1, 5'd4);
      expectWrite(5'd22, 32'h22222222);
      idleCycle();
      checkOutput("pre_rst_full", lsu_rdy, 0);
      checkOutput("pre_rst_busy1", busy1, SB);
      checkOutput("pre_rst_busy2", busy2, SB);
      checkOutput("pre_rst_rd_e", rd_e, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_rd_e", rd_e, 0);
      checkOutput("mid_rst_lsu_rdy", lsu_rdy, 1);
      checkOutput("mid_rst_busy1", busy1, 0);
      checkOutput("mid_rst_busy2", busy2, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) idleCycle();
      checkOutput("post_rst_rd_e", rd_e, 0);
      checkOutput("post_rst_lsu_rdy", lsu_rdy, 1);
      checkOutput("post_rst_busy1", busy1, 0);

      repeat (2) idleCycle();
      checkOutput("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
